// File: rtl/fifo_id_stage_pkg.sv
// fifo_id_stage_pkg: shared state encodings, flush-cause codes and widths for the fetch-to-decode stage
package fifo_id_stage_pkg;

    localparam int CAUSE_W = 2;

    typedef enum logic [1:0] {
        FIFO_ID_EMPTY = 2'd0,
        FIFO_ID_ONE   = 2'd1,
        FIFO_ID_FULL  = 2'd2
    } state_e;

    typedef enum logic [CAUSE_W-1:0] {
        CAUSE_BRANCH = 2'd0,
        CAUSE_EXC    = 2'd1,
        CAUSE_ERTN   = 2'd2,
        CAUSE_IDLE   = 2'd3
    } cause_e;

endpackage

// File: rtl/fifo_id_stage_if.sv
// fifo_id_stage_if: fetch-buffer side, decoder side, flush and status signals of the stage
interface fifo_id_stage_if #(
    parameter int ISSUE_W = 2,
    parameter int INST_W  = 32,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 32
);
    import fifo_id_stage_pkg::*;

    logic                      fifo_id_flush;
    logic [CAUSE_W-1:0]        fifo_id_flush_cause;
    logic                      fifo_valid;
    logic                      fifo_ready;
    logic                      fetch_buf_empty;
    logic [ISSUE_W*INST_W-1:0] inst_i;
    logic [ISSUE_W*PC_W-1:0]   pc_i;
    logic [ISSUE_W-1:0]        lane_mask_i;
    logic                      id_ready;
    logic                      id_valid;
    logic [ISSUE_W*INST_W-1:0] inst_o;
    logic [ISSUE_W*PC_W-1:0]   pc_o;
    logic [ISSUE_W-1:0]        lane_mask_o;
    logic [CAUSE_W-1:0]        flush_cause_o;
    logic [CNT_W-1:0]          stall_cnt_o;

    modport master (
        output fifo_id_flush, fifo_id_flush_cause, fifo_valid, fetch_buf_empty,
               inst_i, pc_i, lane_mask_i, id_ready,
        input  fifo_ready, id_valid, inst_o, pc_o, lane_mask_o, flush_cause_o, stall_cnt_o
    );

    modport slave (
        input  fifo_id_flush, fifo_id_flush_cause, fifo_valid, fetch_buf_empty,
               inst_i, pc_i, lane_mask_i, id_ready,
        output fifo_ready, id_valid, inst_o, pc_o, lane_mask_o, flush_cause_o, stall_cnt_o
    );

endinterface

// File: rtl/fifo_id_stage_slot.sv
// fifo_id_slot: one bundle entry (inst, pc, lane mask) with load enable and mask clear
module fifo_id_slot #(
    parameter int ISSUE_W = 2,
    parameter int INST_W  = 32,
    parameter int PC_W    = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clr_i,
    input  logic                      ld_i,
    input  logic [ISSUE_W*INST_W-1:0] inst_i,
    input  logic [ISSUE_W*PC_W-1:0]   pc_i,
    input  logic [ISSUE_W-1:0]        mask_i,
    output logic [ISSUE_W*INST_W-1:0] inst_o,
    output logic [ISSUE_W*PC_W-1:0]   pc_o,
    output logic [ISSUE_W-1:0]        mask_o
);

    logic [ISSUE_W*INST_W-1:0] inst_q;
    logic [ISSUE_W*PC_W-1:0]   pc_q;
    logic [ISSUE_W-1:0]        mask_q;

    // Entry register: clear drops only the lane mask, so the stale payload is harmless
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            inst_q <= '0;
            pc_q   <= '0;
            mask_q <= '0;
        end else if (clr_i) begin
            mask_q <= '0;
        end else if (ld_i) begin
            inst_q <= inst_i;
            pc_q   <= pc_i;
            mask_q <= mask_i;
        end
    end

    assign inst_o = inst_q;
    assign pc_o   = pc_q;
    assign mask_o = mask_q;

endmodule

// File: rtl/fifo_id_stage.sv
// fifo_id_stage: two-entry skid pipeline register between fetch buffer and decoder with flush and stall count
module fifo_id_stage #(
    parameter int ISSUE_W = 2,
    parameter int INST_W  = 32,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    fifo_id_stage_if.slave   bus
);
    import fifo_id_stage_pkg::*;

    localparam int IW = ISSUE_W * INST_W;
    localparam int PW = ISSUE_W * PC_W;

    state_e             state_q, state_d;
    logic               in_fire, out_fire;
    logic               main_ld, skid_ld, from_skid;
    logic [IW-1:0]      skid_inst, main_src_inst;
    logic [PW-1:0]      skid_pc, main_src_pc;
    logic [ISSUE_W-1:0] skid_mask, main_src_mask;
    logic [CAUSE_W-1:0] cause_q;
    logic [CNT_W-1:0]   cnt_q;

    // Handshake flags depend only on the state register, keeping id_ready off every output path
    assign bus.id_valid   = state_q != FIFO_ID_EMPTY;
    assign bus.fifo_ready = state_q != FIFO_ID_FULL;
    assign in_fire  = bus.fifo_valid & ~bus.fetch_buf_empty & bus.fifo_ready & (|bus.lane_mask_i);
    assign out_fire = bus.id_valid & bus.id_ready;

    // State register
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state_q <= FIFO_ID_EMPTY;
        else      state_q <= state_d;
    end

    // Next state and entry load controls; flush overrides everything and loads nothing
    always_comb begin
        state_d   = state_q;
        main_ld   = 1'b0;
        skid_ld   = 1'b0;
        from_skid = 1'b0;
        if (bus.fifo_id_flush) begin
            state_d = FIFO_ID_EMPTY;
        end else begin
            case (state_q)
                FIFO_ID_EMPTY: begin
                    state_d = in_fire ? FIFO_ID_ONE : FIFO_ID_EMPTY;
                    main_ld = in_fire;
                end
                FIFO_ID_ONE: begin
                    state_d = in_fire ? (out_fire ? FIFO_ID_ONE : FIFO_ID_FULL)
                                      : (out_fire ? FIFO_ID_EMPTY : FIFO_ID_ONE);
                    main_ld = in_fire & out_fire;
                    skid_ld = in_fire & ~out_fire;
                end
                FIFO_ID_FULL: begin
                    state_d   = out_fire ? FIFO_ID_ONE : FIFO_ID_FULL;
                    main_ld   = out_fire;
                    from_skid = 1'b1;
                end
                default: state_d = FIFO_ID_EMPTY;
            endcase
        end
    end

    assign main_src_inst = from_skid ? skid_inst : bus.inst_i;
    assign main_src_pc   = from_skid ? skid_pc   : bus.pc_i;
    assign main_src_mask = from_skid ? skid_mask : bus.lane_mask_i;

    fifo_id_slot #(.ISSUE_W(ISSUE_W), .INST_W(INST_W), .PC_W(PC_W)) u_main (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (bus.fifo_id_flush),
        .ld_i   (main_ld),
        .inst_i (main_src_inst),
        .pc_i   (main_src_pc),
        .mask_i (main_src_mask),
        .inst_o (bus.inst_o),
        .pc_o   (bus.pc_o),
        .mask_o (bus.lane_mask_o)
    );

    fifo_id_slot #(.ISSUE_W(ISSUE_W), .INST_W(INST_W), .PC_W(PC_W)) u_skid (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (bus.fifo_id_flush),
        .ld_i   (skid_ld),
        .inst_i (bus.inst_i),
        .pc_i   (bus.pc_i),
        .mask_i (bus.lane_mask_i),
        .inst_o (skid_inst),
        .pc_o   (skid_pc),
        .mask_o (skid_mask)
    );

    // Flush cause capture
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)                   cause_q <= '0;
        else if (bus.fifo_id_flush) cause_q <= bus.fifo_id_flush_cause;
    end

    // Saturating decoder back-pressure counter; survives flush
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)                                        cnt_q <= '0;
        else if (bus.id_valid & ~bus.id_ready & ~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.flush_cause_o = cause_q;
    assign bus.stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fifo_id_stage.sv
// tb_fifo_id_stage: table-driven checks of the skid stage plus reset and parameter-sweep sequences
module tb_fifo_id_stage;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fifo_id_stage_if #(.ISSUE_W(2), .INST_W(32), .PC_W(32), .CNT_W(32)) b2 ();
    fifo_id_stage_if #(.ISSUE_W(4), .INST_W(32), .PC_W(32), .CNT_W(3))  b4 ();
    fifo_id_stage_if #(.ISSUE_W(1), .INST_W(32), .PC_W(32), .CNT_W(32)) b1 ();

    fifo_id_stage #(.ISSUE_W(2), .INST_W(32), .PC_W(32), .CNT_W(32)) dut2 (.clk(clk), .rstn(rstn), .bus(b2));
    fifo_id_stage #(.ISSUE_W(4), .INST_W(32), .PC_W(32), .CNT_W(3))  dut4 (.clk(clk), .rstn(rstn), .bus(b4));
    fifo_id_stage #(.ISSUE_W(1), .INST_W(32), .PC_W(32), .CNT_W(32)) dut1 (.clk(clk), .rstn(rstn), .bus(b1));

    typedef struct {
        logic        v, e;
        logic [1:0]  m;
        logic [31:0] pc;
        logic        r, fl;
        logic [1:0]  c;
        logic        x_iv, x_fr;
        logic [1:0]  x_m;
        logic [31:0] x_pc;
        logic [31:0] x_cnt;
        logic [1:0]  x_c;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic e, input logic [1:0] m, input logic [31:0] p,
                         input logic r, input logic fl, input logic [1:0] c);
        b2.fifo_valid          = v;
        b2.fetch_buf_empty     = e;
        b2.lane_mask_i         = m;
        b2.pc_i                = {p + 32'd4, p};
        b2.inst_i              = {~(p + 32'd4), ~p};
        b2.id_ready            = r;
        b2.fifo_id_flush       = fl;
        b2.fifo_id_flush_cause = c;
    endtask

    initial begin
        logic [31:0] xp;
        vt[0]  = '{1'b1,1'b0,2'b11,32'h1c000000,1'b1,1'b0,2'd0, 1'b1,1'b1,2'b11,32'h1c000000,32'd0,2'd0};
        vt[1]  = '{1'b1,1'b0,2'b11,32'h1c000004,1'b1,1'b0,2'd0, 1'b1,1'b1,2'b11,32'h1c000004,32'd0,2'd0};
        vt[2]  = '{1'b1,1'b0,2'b11,32'h1c000008,1'b1,1'b0,2'd0, 1'b1,1'b1,2'b11,32'h1c000008,32'd0,2'd0};
        vt[3]  = '{1'b1,1'b0,2'b11,32'h1c00000c,1'b1,1'b0,2'd0, 1'b1,1'b1,2'b11,32'h1c00000c,32'd0,2'd0};
        vt[4]  = '{1'b0,1'b0,2'b00,32'h00000000,1'b1,1'b0,2'd0, 1'b0,1'b1,2'b11,32'h1c00000c,32'd0,2'd0};
        vt[5]  = '{1'b1,1'b0,2'b11,32'h1c000100,1'b0,1'b0,2'd0, 1'b1,1'b1,2'b11,32'h1c000100,32'd0,2'd0};
        vt[6]  = '{1'b1,1'b0,2'b11,32'h1c000110,1'b0,1'b0,2'd0, 1'b1,1'b0,2'b11,32'h1c000100,32'd1,2'd0};
        vt[7]  = '{1'b1,1'b0,2'b11,32'h1c000120,1'b0,1'b0,2'd0, 1'b1,1'b0,2'b11,32'h1c000100,32'd2,2'd0};
        vt[8]  = '{1'b0,1'b0,2'b00,32'h00000000,1'b0,1'b0,2'd0, 1'b1,1'b0,2'b11,32'h1c000100,32'd3,2'd0};
        vt[9]  = '{1'b0,1'b0,2'b00,32'h00000000,1'b1,1'b0,2'd0, 1'b1,1'b1,2'b11,32'h1c000110,32'd3,2'd0};
        vt[10] = '{1'b0,1'b0,2'b00,32'h00000000,1'b1,1'b0,2'd0, 1'b0,1'b1,2'b11,32'h1c000110,32'd3,2'd0};
        vt[11] = '{1'b1,1'b0,2'b00,32'h1c000200,1'b1,1'b0,2'd0, 1'b0,1'b1,2'b11,32'h1c000110,32'd3,2'd0};
        vt[12] = '{1'b1,1'b1,2'b11,32'h1c000200,1'b1,1'b0,2'd0, 1'b0,1'b1,2'b11,32'h1c000110,32'd3,2'd0};
        vt[13] = '{1'b1,1'b0,2'b01,32'h1c000300,1'b0,1'b0,2'd0, 1'b1,1'b1,2'b01,32'h1c000300,32'd3,2'd0};
        vt[14] = '{1'b1,1'b0,2'b11,32'h1c000310,1'b0,1'b0,2'd0, 1'b1,1'b0,2'b01,32'h1c000300,32'd4,2'd0};
        vt[15] = '{1'b1,1'b0,2'b11,32'h1c000320,1'b0,1'b1,2'd1, 1'b0,1'b1,2'b00,32'h1c000300,32'd5,2'd1};
        vt[16] = '{1'b1,1'b0,2'b11,32'h1c000400,1'b1,1'b0,2'd0, 1'b1,1'b1,2'b11,32'h1c000400,32'd5,2'd1};
        vt[17] = '{1'b1,1'b0,2'b11,32'h1c000410,1'b1,1'b1,2'd2, 1'b0,1'b1,2'b00,32'h1c000400,32'd5,2'd2};
        vt[18] = '{1'b0,1'b0,2'b00,32'h00000000,1'b1,1'b0,2'd0, 1'b0,1'b1,2'b00,32'h1c000400,32'd5,2'd2};

        drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 2'd0);
        {b4.fifo_valid, b4.fetch_buf_empty, b4.lane_mask_i, b4.id_ready, b4.fifo_id_flush} = '0;
        {b4.fifo_id_flush_cause, b4.inst_i, b4.pc_i} = '0;
        {b1.fifo_valid, b1.fetch_buf_empty, b1.lane_mask_i, b1.id_ready, b1.fifo_id_flush} = '0;
        {b1.fifo_id_flush_cause, b1.inst_i, b1.pc_i} = '0;
        repeat (2) step();
        rstn = 1'b0;

        chk("rst_id_valid", 128'(b2.id_valid), 128'd0);
        chk("rst_fifo_ready", 128'(b2.fifo_ready), 128'd1);
        chk("rst_inst_o", 128'(b2.inst_o), 128'd0);
        chk("rst_pc_o", 128'(b2.pc_o), 128'd0);
        chk("rst_mask_o", 128'(b2.lane_mask_o), 128'd0);
        chk("rst_cause", 128'(b2.flush_cause_o), 128'd0);
        chk("rst_cnt", 128'(b2.stall_cnt_o), 128'd0);

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].v, vt[i].e, vt[i].m, vt[i].pc, vt[i].r, vt[i].fl, vt[i].c);
            step();
            xp = vt[i].x_pc;
            chk($sformatf("v%0d_id_valid", i), 128'(b2.id_valid), 128'(vt[i].x_iv));
            chk($sformatf("v%0d_fifo_ready", i), 128'(b2.fifo_ready), 128'(vt[i].x_fr));
            chk($sformatf("v%0d_mask_o", i), 128'(b2.lane_mask_o), 128'(vt[i].x_m));
            chk($sformatf("v%0d_pc_o", i), 128'(b2.pc_o), 128'({xp + 32'd4, xp}));
            chk($sformatf("v%0d_inst_o", i), 128'(b2.inst_o), 128'({~(xp + 32'd4), ~xp}));
            chk($sformatf("v%0d_stall_cnt", i), 128'(b2.stall_cnt_o), 128'(vt[i].x_cnt));
            chk($sformatf("v%0d_cause", i), 128'(b2.flush_cause_o), 128'(vt[i].x_c));
        end

        drive(1'b1, 1'b0, 2'b11, 32'h1c000500, 1'b0, 1'b0, 2'd0);
        step();
        drive(1'b1, 1'b0, 2'b11, 32'h1c000510, 1'b0, 1'b0, 2'd0);
        step();
        chk("pre_rst_full", 128'(b2.fifo_ready), 128'd0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 2'd0);
        #2;
        rstn = 1'b1;
        #1;
        chk("arst_id_valid", 128'(b2.id_valid), 128'd0);
        chk("arst_fifo_ready", 128'(b2.fifo_ready), 128'd1);
        chk("arst_mask_o", 128'(b2.lane_mask_o), 128'd0);
        chk("arst_pc_o", 128'(b2.pc_o), 128'd0);
        chk("arst_inst_o", 128'(b2.inst_o), 128'd0);
        chk("arst_cnt", 128'(b2.stall_cnt_o), 128'd0);
        chk("arst_cause", 128'(b2.flush_cause_o), 128'd0);
        step();
        rstn = 1'b0;

        b4.fifo_valid  = 1'b1;
        b4.lane_mask_i = 4'b0111;
        b4.id_ready    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b4.pc_i[k*32 +: 32]   = 32'h1c000000 + 32'(k) * 32'd4;
            b4.inst_i[k*32 +: 32] = (k == 3) ? 32'hdeadbeef : 32'(k);
        end
        step();
        chk("w4_id_valid", 128'(b4.id_valid), 128'd1);
        chk("w4_mask_o", 128'(b4.lane_mask_o), 128'b0111);
        chk("w4_inst_lane3", 128'(b4.inst_o[127:96]), 128'hdeadbeef);
        chk("w4_pc_lane3", 128'(b4.pc_o[127:96]), 128'h1c00000c);
        b4.fifo_valid = 1'b0;
        b4.id_ready   = 1'b0;
        repeat (6) step();
        chk("w4_cnt_6", 128'(b4.stall_cnt_o), 128'd6);
        repeat (4) step();
        chk("w4_cnt_sat", 128'(b4.stall_cnt_o), 128'd7);

        b1.fifo_valid  = 1'b1;
        b1.lane_mask_i = 1'b1;
        b1.id_ready    = 1'b1;
        b1.pc_i        = 32'h1c000040;
        b1.inst_i      = 32'h12345678;
        step();
        b1.fifo_valid = 1'b0;
        chk("w1_id_valid", 128'(b1.id_valid), 128'd1);
        chk("w1_mask_o", 128'(b1.lane_mask_o), 128'd1);
        chk("w1_inst_o", 128'(b1.inst_o), 128'h12345678);
        chk("w1_pc_o", 128'(b1.pc_o), 128'h1c000040);
        step();
        chk("w1_drained", 128'(b1.id_valid), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
